mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single external memory port between icache line refills (read-only) and dcache line refills and writebacks (read or write).
- Sits below u_icache and u_dcache, outside the pipeline. Their `valid` outputs stay low while they wait on this block, so stalls propagate through `pipeline_en`.
- Sequences one whole-line burst at a time. Round-robin arbitration between the two requesters.

Parameters:
- BURST_LEN, 4, words per cache line (power of 2, ≥2); burst base = addr with low log2(BURST_LEN*4) bits cleared.
- ADDR_W, 32, address width.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- i_req  input  1  icache refill request; held high until i_done
- i_addr  input  ADDR_W  icache miss address; stable while i_req
- i_rvalid  output  1  one-cycle pulse: i_rdata valid
- i_rdata  output  32  refill word
- i_done  output  1  one-cycle pulse: icache burst complete
- d_req  input  1  dcache request; held high until d_done
- d_we  input  1  1 = writeback burst, 0 = refill; stable while d_req
- d_addr  input  ADDR_W  dcache line address; stable while d_req
- d_wdata  input  32  write word for index `beat`
- d_rvalid  output  1  one-cycle pulse: d_rdata valid
- d_rdata  output  32  refill word
- d_done  output  1  one-cycle pulse: dcache burst complete
- beat  output  log2(BURST_LEN)  index of the command beat currently presented
- mem_valid  output  1  command beat valid
- mem_ready  input  1  memory accepts beat when mem_valid && mem_ready
- mem_we  output  1  command is a write
- mem_addr  output  ADDR_W  beat address
- mem_wdata  output  32  write data (= d_wdata)
- mem_rvalid  input  1  read data return, in order, any latency ≥1 after accept
- mem_rdata  input  32  read data

Behaviour:
- Reset: state = IDLE; issue_cnt = 0; rcv_cnt = 0; owner = I; last_owner = D. All outputs are 0.
- States:
  - IDLE
    - No req: stay in IDLE.
    - Only one req: grant that requester.
    - Both reqs: grant the requester that is not last_owner.
    - On grant: latch owner, we (d_we for D, 0 for I) and base address; clear counters; go to BUSY.
    - mem_valid = 0.
  - BUSY
    - mem_valid = (issue_cnt < BURST_LEN).
    - mem_addr = base + 4*issue_cnt (no carry out of the line; wrap inside width is impossible by alignment).
    - beat = issue_cnt[log2-1:0]; mem_we = latched we.
    - Each accept increments issue_cnt.
    - Read burst: each mem_rvalid pulses owner's x_rvalid in the same cycle, with x_rdata = mem_rdata (combinational pass-through), and increments rcv_cnt.
    - Read burst ends when rcv_cnt reaches BURST_LEN. Write burst ends on the BURST_LEN-th accept. Either way → DONE.
  - DONE: owner's x_done = 1 for exactly one cycle; last_owner ← owner; → IDLE.
- Minimum gap between bursts is one IDLE cycle. Requester drops req on the edge after x_done, and req is not sampled during DONE.
- Non-owner outputs stay 0 at all times.
- mem_rvalid in IDLE, DONE, or during a write burst: ignored, no x_rvalid.
- Accept and rvalid in the same cycle: both counters update.
- Requester dropping req mid-burst is illegal. The arbiter finishes the burst and still pulses done.
- rst mid-burst: next cycle everything is back to reset values, with no done pulse. Memory responses still in flight are the memory model's responsibility (it is reset too).
- Latency, single requester, mem_ready = 1, read latency L: first mem_valid 1 cycle after req; i_done at cycle 1 + BURST_LEN + L.

Decomposition:
- Add to defs.sv:
  - `ARB_IDLE`/`ARB_BUSY`/`ARB_DONE` (2-bit state encodings)
  - `ARB_OWN_I`/`ARB_OWN_D`
- Single module. No sub-module is natural; round-robin for two requesters is one flop.

Test Plan (BURST_LEN=4):
1. i_req, i_addr=0x8000_0014, mem_ready=1, rvalid 2 cycles after each accept with data 0xA0..0xA3 → mem_addr 0x8000_0010/14/18/1C; i_rvalid ×4 with data in order; i_done one cycle after the 4th rvalid; d_* remain 0.
2. d_req, d_we=1, d_addr=0x0000_1008, mem_ready pattern 1,0,1,0,… → 4 accepts at 0x1000/04/08/0C with beat 0..3; mem_we=1; mem_wdata = d_wdata; d_done the cycle after the 4th accept.
3. i_req and d_req rise together right after reset → icache burst first, then dcache. Repeat with both held → grants alternate I,D,I,D, with exactly one IDLE cycle between bursts.
4. d read burst in flight, mem_rvalid pulsed during IDLE and DONE → no d_rvalid or i_rvalid on those cycles; rcv_cnt unaffected.
5. rst asserted for one cycle after 2 of 4 read beats returned → next cycle mem_valid=0, no done pulse, state IDLE. A new i_req at 0x40 issues beats 0x40..0x4C starting from beat 0.
6. Read with accept and rvalid coinciding (mem_ready=1, latency 1) → 4 rvalids on consecutive cycles; done one cycle after the last.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : State and owner encodings shared by the memory-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_BUSY = 2'd1;
    localparam logic [1:0] ARB_DONE = 2'd2;

    localparam logic ARB_OWN_I = 1'b0;
    localparam logic ARB_OWN_D = 1'b1;

    // Round-robin pick: a lone requester wins, otherwise whoever went last yields.
    function automatic logic pick_owner(input logic i_req_v, input logic d_req_v,
                                        input logic last_owner);
        logic own;
        own = ARB_OWN_I;
        if (d_req_v && (!i_req_v || (last_owner == ARB_OWN_I)))
            own = ARB_OWN_D;
        return own;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin sharing of one external memory port between
//               icache line refills and dcache line refills / writebacks.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int ADDR_W    = 32
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic                          i_req,
    input  logic [ADDR_W-1:0]             i_addr,
    output logic                          i_rvalid,
    output logic [31:0]                   i_rdata,
    output logic                          i_done,

    input  logic                          d_req,
    input  logic                          d_we,
    input  logic [ADDR_W-1:0]             d_addr,
    input  logic [31:0]                   d_wdata,
    output logic                          d_rvalid,
    output logic [31:0]                   d_rdata,
    output logic                          d_done,

    output logic [$clog2(BURST_LEN)-1:0]  beat,
    output logic                          mem_valid,
    input  logic                          mem_ready,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [31:0]                   mem_wdata,
    input  logic                          mem_rvalid,
    input  logic [31:0]                   mem_rdata
);

    localparam int c_beat_w = $clog2(BURST_LEN);
    localparam int c_cnt_w  = c_beat_w + 1;
    localparam int c_off_w  = $clog2(BURST_LEN * 4);

    localparam logic [c_cnt_w-1:0] c_len  = c_cnt_w'(BURST_LEN);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0]  c_base_mask = {{(ADDR_W - c_off_w){1'b1}}, {c_off_w{1'b0}}};

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic                r_owner;
    logic                r_last_owner;
    logic                r_we;
    logic [ADDR_W-1:0]   r_base;
    logic [c_cnt_w-1:0]  r_issue_cnt;
    logic [c_cnt_w-1:0]  r_rcv_cnt;

    logic                w_any_req;
    logic                w_grant_owner;
    logic [ADDR_W-1:0]   w_grant_addr;
    logic                w_issuing;
    logic                w_accept;
    logic                w_rd_beat;
    logic                w_burst_end;

    assign w_any_req     = i_req | d_req;
    assign w_grant_owner = pick_owner(i_req, d_req, r_last_owner);
    assign w_grant_addr  = (w_grant_owner == ARB_OWN_D) ? d_addr : i_addr;

    assign w_issuing = (r_state == ARB_BUSY) && (r_issue_cnt < c_len);
    assign w_accept  = w_issuing && mem_ready;
    // Read data is only meaningful while a read burst owns the port.
    assign w_rd_beat = (r_state == ARB_BUSY) && !r_we && mem_rvalid;

    assign w_burst_end = r_we ? (w_accept && (r_issue_cnt == c_last))
                              : (w_rd_beat && (r_rcv_cnt == c_last));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE: if (w_any_req)   w_next_state = ARB_BUSY;
            ARB_BUSY: if (w_burst_end) w_next_state = ARB_DONE;
            ARB_DONE:                  w_next_state = ARB_IDLE;
            default:                   w_next_state = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner      <= ARB_OWN_I;
            r_last_owner <= ARB_OWN_D;
            r_we         <= 1'b0;
            r_base       <= '0;
            r_issue_cnt  <= '0;
            r_rcv_cnt    <= '0;
        end else begin
            if ((r_state == ARB_IDLE) && w_any_req) begin
                r_owner     <= w_grant_owner;
                r_we        <= (w_grant_owner == ARB_OWN_D) && d_we;
                r_base      <= w_grant_addr & c_base_mask;
                r_issue_cnt <= '0;
                r_rcv_cnt   <= '0;
            end else begin
                if (w_accept)  r_issue_cnt <= r_issue_cnt + 1'b1;
                if (w_rd_beat) r_rcv_cnt   <= r_rcv_cnt + 1'b1;
            end
            if (r_state == ARB_DONE) begin
                r_last_owner <= r_owner;
            end
        end
    end

    always_comb begin
        mem_valid = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        beat      = '0;
        i_rvalid  = 1'b0;
        i_rdata   = '0;
        i_done    = 1'b0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
        d_done    = 1'b0;
        if (r_state == ARB_BUSY) begin
            mem_valid = w_issuing;
            mem_we    = r_we;
            beat      = r_issue_cnt[c_beat_w-1:0];
            mem_addr  = r_base | ADDR_W'({r_issue_cnt[c_beat_w-1:0], 2'b00});
            mem_wdata = r_we ? d_wdata : 32'd0;
            if (w_rd_beat) begin
                if (r_owner == ARB_OWN_I) begin
                    i_rvalid = 1'b1;
                    i_rdata  = mem_rdata;
                end else begin
                    d_rvalid = 1'b1;
                    d_rdata  = mem_rdata;
                end
            end
        end
        if (r_state == ARB_DONE) begin
            i_done = (r_owner == ARB_OWN_I);
            d_done = (r_owner == ARB_OWN_D);
        end
    end

endmodule
`default_nettype wire
